// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the word-to-byte memory sequencer and its
// read-capture stage.
package mem_seq_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;

    typedef logic [BEAT_W-1:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    localparam logic IDLE_CE  = 1'b0;
    localparam logic IDLE_CSB = 1'b1;
    localparam logic IDLE_WEB = 1'b1;
    localparam logic IDLE_OEB = 1'b1;

    typedef struct packed {
        logic      valid;
        beat_idx_t idx;
    } rd_tag_t;

    function automatic logic [7:0] word_byte(input logic [8*BEATS-1:0] word, input beat_idx_t k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_word_seq_if.sv
// Word request/response channel plus the byte-wide bus toward the register stage.
interface mem_word_seq_if;

    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [15:0] REQ_ADDR;
    logic [3:0]  REQ_BE;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic [15:0] ADDR;
    logic        CE;
    logic        CSB;
    logic        WEB;
    logic        OEB;
    logic [7:0]  IDATA;
    logic [7:0]  ODATA;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_BE, REQ_WDATA, ODATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA, ADDR, CE, CSB, WEB, OEB, IDATA
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_BE, REQ_WDATA, ODATA,
        output REQ_READY, RSP_VALID, RSP_RDATA, ADDR, CE, CSB, WEB, OEB, IDATA
    );

endinterface

// File: rtl/mem_rd_capture.sv
// Read-return tracking: a tag per read beat travels RD_LAT stages, then the
// matching ODATA byte lands in its lane of the assembled word.
module mem_rd_capture
    import mem_seq_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic               CLK,
    input  logic               flush,
    input  logic               tag_valid,
    input  beat_idx_t          tag_idx,
    input  logic [7:0]         ODATA,
    output logic [8*BEATS-1:0] rdata,
    output logic               last_cap
);

    rd_tag_t            pipe_r [RD_LAT];
    logic [8*BEATS-1:0] lanes_r;
    rd_tag_t            head_s;

    assign head_s   = pipe_r[RD_LAT-1];
    assign rdata    = lanes_r;
    assign last_cap = head_s.valid && (head_s.idx == LAST_BEAT);

    // Tag pipeline: the tag enters the cycle after its beat is on the bus.
    always_ff @(posedge CLK) begin
        if (flush) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= {tag_valid, tag_idx};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Byte-lane assembly; cleared on flush, otherwise holds between captures.
    always_ff @(posedge CLK) begin
        if (flush) begin
            lanes_r <= '0;
        end else if (head_s.valid) begin
            lanes_r[{head_s.idx, 3'b000} +: 8] <= ODATA;
        end else begin
            lanes_r <= lanes_r;
        end
    end

endmodule

// File: rtl/mem_word_seq.sv
// Splits 32-bit word requests into four byte-bus beats and, for reads,
// assembles the returned bytes into a one-cycle word response.
module mem_word_seq
    import mem_seq_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic           CLK,
    input  logic           RSTN,
    mem_word_seq_if.slave  mws
);

    seq_state_t  state_r;
    beat_idx_t   beat_r;
    logic        we_r;
    logic [15:0] base_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        ready_r;
    logic        rsp_valid_r;
    logic [15:0] addr_r;
    logic        ce_r;
    logic        csb_r;
    logic        web_r;
    logic        oeb_r;
    logic [7:0]  idata_r;
    logic        rd_beat_r;

    logic        accept_s;
    logic        flush_s;
    logic        last_cap_s;
    logic [31:0] rdata_s;
    logic [1:0]  addr_lsb_unused_s;

    logic        drv_we_s;
    logic [15:0] drv_base_s;
    logic [3:0]  drv_be_s;
    logic [31:0] drv_wdata_s;
    beat_idx_t   drv_k_s;

    logic [15:0] beat_addr_s;
    logic [7:0]  beat_idata_s;
    logic        beat_ce_s;
    logic        beat_csb_s;
    logic        beat_web_s;
    logic        beat_oeb_s;
    logic        beat_rd_s;

    assign accept_s          = mws.REQ_VALID && ready_r;
    assign flush_s           = !RSTN || accept_s;
    assign addr_lsb_unused_s = mws.REQ_ADDR[1:0];

    // Source of the next beat: fresh request on accept, latched request otherwise.
    always_comb begin
        drv_we_s    = we_r;
        drv_base_s  = base_r;
        drv_be_s    = be_r;
        drv_wdata_s = wdata_r;
        drv_k_s     = beat_r + 2'd1;
        if (accept_s) begin
            drv_we_s    = mws.REQ_WE;
            drv_base_s  = {mws.REQ_ADDR[15:2], 2'b00};
            drv_be_s    = mws.REQ_BE;
            drv_wdata_s = mws.REQ_WDATA;
            drv_k_s     = 2'd0;
        end else begin
            drv_k_s     = beat_r + 2'd1;
        end
    end

    // Bus values for that beat; a disabled write byte leaves the bus idle.
    always_comb begin
        beat_addr_s  = addr_r;
        beat_idata_s = idata_r;
        beat_ce_s    = IDLE_CE;
        beat_csb_s   = IDLE_CSB;
        beat_web_s   = IDLE_WEB;
        beat_oeb_s   = IDLE_OEB;
        beat_rd_s    = 1'b0;
        if (!drv_we_s) begin
            beat_addr_s = drv_base_s + {14'd0, drv_k_s};
            beat_ce_s   = 1'b1;
            beat_csb_s  = 1'b0;
            beat_oeb_s  = 1'b0;
            beat_rd_s   = 1'b1;
        end else if (drv_be_s[drv_k_s]) begin
            beat_addr_s  = drv_base_s + {14'd0, drv_k_s};
            beat_idata_s = word_byte(drv_wdata_s, drv_k_s);
            beat_ce_s    = 1'b1;
            beat_csb_s   = 1'b0;
            beat_web_s   = 1'b0;
        end else begin
            beat_rd_s    = 1'b0;
        end
    end

    // Sequencer FSM with registered handshake and byte-bus outputs.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r     <= ST_IDLE;
            beat_r      <= 2'd0;
            we_r        <= 1'b0;
            base_r      <= 16'h0000;
            be_r        <= 4'h0;
            wdata_r     <= 32'h0000_0000;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            addr_r      <= 16'h0000;
            ce_r        <= IDLE_CE;
            csb_r       <= IDLE_CSB;
            web_r       <= IDLE_WEB;
            oeb_r       <= IDLE_OEB;
            idata_r     <= 8'h00;
            rd_beat_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    rsp_valid_r <= 1'b0;
                    if (accept_s) begin
                        we_r      <= drv_we_s;
                        base_r    <= drv_base_s;
                        be_r      <= drv_be_s;
                        wdata_r   <= drv_wdata_s;
                        beat_r    <= 2'd0;
                        ready_r   <= 1'b0;
                        state_r   <= ST_ISSUE;
                        addr_r    <= beat_addr_s;
                        idata_r   <= beat_idata_s;
                        ce_r      <= beat_ce_s;
                        csb_r     <= beat_csb_s;
                        web_r     <= beat_web_s;
                        oeb_r     <= beat_oeb_s;
                        rd_beat_r <= beat_rd_s;
                    end else begin
                        ready_r   <= 1'b1;
                        state_r   <= ST_IDLE;
                        ce_r      <= IDLE_CE;
                        csb_r     <= IDLE_CSB;
                        web_r     <= IDLE_WEB;
                        oeb_r     <= IDLE_OEB;
                        rd_beat_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (beat_r == LAST_BEAT) begin
                        ce_r      <= IDLE_CE;
                        csb_r     <= IDLE_CSB;
                        web_r     <= IDLE_WEB;
                        oeb_r     <= IDLE_OEB;
                        rd_beat_r <= 1'b0;
                        if (we_r) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            ready_r     <= 1'b1;
                        end else begin
                            state_r     <= ST_DRAIN;
                        end
                    end else begin
                        beat_r    <= drv_k_s;
                        addr_r    <= beat_addr_s;
                        idata_r   <= beat_idata_s;
                        ce_r      <= beat_ce_s;
                        csb_r     <= beat_csb_s;
                        web_r     <= beat_web_s;
                        oeb_r     <= beat_oeb_s;
                        rd_beat_r <= beat_rd_s;
                    end
                end
                ST_DRAIN: begin
                    ce_r      <= IDLE_CE;
                    csb_r     <= IDLE_CSB;
                    web_r     <= IDLE_WEB;
                    oeb_r     <= IDLE_OEB;
                    rd_beat_r <= 1'b0;
                    if (last_cap_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        ready_r     <= 1'b1;
                    end else begin
                        state_r     <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    ce_r        <= IDLE_CE;
                    csb_r       <= IDLE_CSB;
                    web_r       <= IDLE_WEB;
                    oeb_r       <= IDLE_OEB;
                    rd_beat_r   <= 1'b0;
                end
            endcase
        end
    end

    mem_rd_capture #(
        .RD_LAT (RD_LAT)
    ) u_capture (
        .CLK       (CLK),
        .flush     (flush_s),
        .tag_valid (rd_beat_r),
        .tag_idx   (beat_r),
        .ODATA     (mws.ODATA),
        .rdata     (rdata_s),
        .last_cap  (last_cap_s)
    );

    assign mws.REQ_READY = ready_r;
    assign mws.RSP_VALID = rsp_valid_r;
    assign mws.RSP_RDATA = rdata_s;
    assign mws.ADDR      = addr_r;
    assign mws.CE        = ce_r;
    assign mws.CSB       = csb_r;
    assign mws.WEB       = web_r;
    assign mws.OEB       = oeb_r;
    assign mws.IDATA     = idata_r;

endmodule
